// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel/line counters advanced by a pixel-rate
// enable, with registered syncs, display enable and line/frame strobes aligned to the counters.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int CW         = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] ONE    = CW'(1);

    // Region bounds carry one extra bit so an end equal to 2**CW does not alias to 0.
    localparam logic [CW:0] H_ACT_END  = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0] H_SYNC_BEG = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0] H_SYNC_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0] V_ACT_END  = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0] V_SYNC_BEG = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0] V_SYNC_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

    function automatic logic in_range(
        input logic [CW-1:0] pos,
        input logic [CW:0]   lo,
        input logic [CW:0]   hi
    );
        logic [CW:0] pos_ext;
        pos_ext = {1'b0, pos};
        return (pos_ext >= lo) && (pos_ext < hi);
    endfunction

    function automatic logic sync_level(input logic asserted, input logic pol);
        return asserted ? pol : ~pol;
    endfunction

    logic [CW-1:0] hcount_q, hcount_d;
    logic [CW-1:0] vcount_q, vcount_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;

    logic          h_wrap_s;
    logic          v_wrap_s;
    logic [CW-1:0] hcount_inc_s;
    logic [CW-1:0] vcount_inc_s;

    // Next raster position; >= keeps a corrupted counter from running past the line/frame end.
    always_comb begin
        h_wrap_s     = (hcount_q >= H_LAST);
        v_wrap_s     = (vcount_q >= V_LAST);
        hcount_inc_s = h_wrap_s ? ZERO : (hcount_q + ONE);
        if (h_wrap_s) begin
            vcount_inc_s = v_wrap_s ? ZERO : (vcount_q + ONE);
        end else begin
            vcount_inc_s = vcount_q;
        end
    end

    // Next register values; syncs and de decode the same position the counters will present.
    always_comb begin
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (enable) begin
            hcount_d      = hcount_inc_s;
            vcount_d      = vcount_inc_s;
            hsync_d       = sync_level(in_range(hcount_inc_s, H_SYNC_BEG, H_SYNC_END), H_SYNC_POL);
            vsync_d       = sync_level(in_range(vcount_inc_s, V_SYNC_BEG, V_SYNC_END), V_SYNC_POL);
            de_d          = in_range(hcount_inc_s, {(CW+1){1'b0}}, H_ACT_END) &&
                            in_range(vcount_inc_s, {(CW+1){1'b0}}, V_ACT_END);
            line_start_d  = (hcount_inc_s == ZERO);
            frame_start_d = (hcount_inc_s == ZERO) && (vcount_inc_s == ZERO);
        end else begin
            line_start_d  = 1'b0;
            frame_start_d = 1'b0;
        end
    end

    // State registers; reset parks at the last position so the first tick lands on (0,0).
    always_ff @(posedge clk) begin
        if (reset) begin
            hcount_q      <= H_LAST;
            vcount_q      <= V_LAST;
            hsync_q       <= ~H_SYNC_POL;
            vsync_q       <= ~V_SYNC_POL;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule
